ipv4_header_check: RTL

Receive-side IPv4 header checker, the counterpart of the transmit checksum inserter. It is triggered by the Rx parser request, reads the 10-word IPv4 header from the Rx packet buffer, and verifies the one's-complement checksum and the version/IHL byte. It also optionally checks the destination address, and captures the protocol and total length for the upper-layer dispatcher. It sits between the Ethernet Rx buffer and the UDP/ICMP parsers.

---
 rtl/ipv4_pkg.sv | 26 ++
 rtl/ipv4_csum_fold.sv | 29 ++
 rtl/ipv4_header_check.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ipv4_pkg.sv
// Shared IPv4 receive/transmit definitions: buffer layout defaults, header word
// indices, the expected version/IHL byte and the header checker FSM states.
package ipv4_pkg;

   localparam int IP_HEADER_OFFSET_DEFAULT = 7;
   localparam int IP_HEADER_SIZE_DEFAULT   = 10;

   localparam logic [3:0] IPV4_W_VER    = 4'd0;
   localparam logic [3:0] IPV4_W_LEN    = 4'd1;
   localparam logic [3:0] IPV4_W_PROTO  = 4'd4;
   localparam logic [3:0] IPV4_W_CSUM   = 4'd5;
   localparam logic [3:0] IPV4_W_DST_HI = 4'd8;
   localparam logic [3:0] IPV4_W_DST_LO = 4'd9;

   localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
   localparam logic [15:0] IPV4_CSUM_GOOD = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_FOLD1,
      ST_FOLD2,
      ST_CHECK
   } ipv4_state_t;

endpackage

// File: rtl/ipv4_csum_fold.sv
// Registered two-stage end-around-carry fold of a 20-bit one's-complement
// accumulator down to 16 bits; shared with the transmit checksum inserter.
module ipv4_csum_fold (
   input  logic        clock,
   input  logic        reset,
   input  logic        fold1_en,
   input  logic        fold2_en,
   input  logic [19:0] acc,
   output logic [15:0] sum16
);

   logic [16:0] s17;

   // The second stage cannot carry again: when s17[16] is set the low half is at most 16'h000E.
   always_ff @(posedge clock) begin
      if (reset) begin
         s17   <= '0;
         sum16 <= '0;
      end else begin
         if (fold1_en) begin
            s17 <= {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
         end
         if (fold2_en) begin
            sum16 <= s17[15:0] + {15'b0, s17[16]};
         end
      end
   end

endmodule

// File: rtl/ipv4_header_check.sv
// Receive-side IPv4 header checker: reads the 10-word header from the Rx buffer,
// verifies checksum and version/IHL, captures protocol and total length.
// Define IPV4_DST_CHECK_EN to also compare the destination address with My_IP.
module ipv4_header_check
   import ipv4_pkg::*;
#(
   parameter int Eth_WORD_WIDTH   = 16,
   parameter int IP_HEADER_OFFSET = IP_HEADER_OFFSET_DEFAULT,
   parameter int IP_HEADER_SIZE   = IP_HEADER_SIZE_DEFAULT
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Rx_Parcer_RQ,
   output logic [10:0]               Rx_Addr,
   input  logic [Eth_WORD_WIDTH-1:0] Rx_Data,
   input  logic [31:0]               My_IP,
   output logic                      Busy,
   output logic                      IPv4_Check_Done,
   output logic                      IPv4_Header_OK,
   output logic                      Err_Checksum,
   output logic                      Err_Version,
   output logic                      Err_Dst,
   output logic [7:0]                Protocol,
   output logic [15:0]               Total_Length
);

   ipv4_state_t state;
   ipv4_state_t state_next;

   logic        rq_prev;
   logic        start;
   logic [3:0]  word_idx;
   logic        phase;
   logic        read_first;
   logic        read_sample;
   logic        last_word;
   logic [19:0] acc;
   logic [15:0] sum16;
   logic        csum_err;
   logic        dst_err;
   logic        ver_ok;
   logic [7:0]  proto_cap;
   logic [15:0] len_cap;

   assign start       = Rx_Parcer_RQ && !rq_prev && (state == ST_IDLE);
   assign read_first  = (state == ST_READ) && (word_idx == 4'd0) && !phase;
   assign read_sample = (state == ST_READ) && phase;
   assign last_word   = (word_idx == 4'(IP_HEADER_SIZE - 1));
   assign csum_err    = (sum16 != IPV4_CSUM_GOOD);

   assign Busy    = (state != ST_IDLE);
   assign Rx_Addr = (state == ST_READ) ? (11'(IP_HEADER_OFFSET) + {7'b0, word_idx}) : 11'd0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Each header word occupies two READ cycles: address, then sample.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_READ;
         ST_READ:  if (phase && last_word) state_next = ST_FOLD1;
         ST_FOLD1: state_next = ST_FOLD2;
         ST_FOLD2: state_next = ST_CHECK;
         ST_CHECK: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rq_prev         <= 1'b0;
         acc             <= '0;
         word_idx        <= '0;
         phase           <= 1'b0;
         ver_ok          <= 1'b0;
         proto_cap       <= '0;
         len_cap         <= '0;
         IPv4_Check_Done <= 1'b0;
         IPv4_Header_OK  <= 1'b0;
         Err_Checksum    <= 1'b0;
         Err_Version     <= 1'b0;
         Protocol        <= '0;
         Total_Length    <= '0;
      end else begin
         rq_prev         <= Rx_Parcer_RQ;
         IPv4_Check_Done <= 1'b0;

         if (start) begin
            acc      <= '0;
            word_idx <= '0;
            phase    <= 1'b0;
         end

         // Previous results stay visible until the new run actually begins reading.
         if (read_first) begin
            IPv4_Header_OK <= 1'b0;
            Err_Checksum   <= 1'b0;
            Err_Version    <= 1'b0;
            Protocol       <= '0;
            Total_Length   <= '0;
         end

         if (state == ST_READ) begin
            phase <= ~phase;
         end

         if (read_sample) begin
            acc      <= acc + 20'(Rx_Data);
            word_idx <= word_idx + 4'd1;
            if (word_idx == IPV4_W_VER) begin
               ver_ok <= (Rx_Data[15:8] == IPV4_VER_IHL);
            end
            if (word_idx == IPV4_W_LEN) begin
               len_cap <= Rx_Data[15:0];
            end
            if (word_idx == IPV4_W_PROTO) begin
               proto_cap <= Rx_Data[7:0];
            end
         end

         if (state == ST_CHECK) begin
            IPv4_Check_Done <= 1'b1;
            Err_Checksum    <= csum_err;
            Err_Version     <= !ver_ok;
            IPv4_Header_OK  <= !(csum_err || !ver_ok || dst_err);
            Protocol        <= proto_cap;
            Total_Length    <= len_cap;
         end
      end
   end

`ifdef IPV4_DST_CHECK_EN
   logic dst_hi_ok;
   logic dst_lo_ok;

   assign dst_err = !(dst_hi_ok && dst_lo_ok);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         dst_hi_ok <= 1'b0;
         dst_lo_ok <= 1'b0;
         Err_Dst   <= 1'b0;
      end else begin
         if (read_first) begin
            Err_Dst <= 1'b0;
         end
         if (read_sample && (word_idx == IPV4_W_DST_HI)) begin
            dst_hi_ok <= (Rx_Data[15:0] == My_IP[31:16]);
         end
         if (read_sample && (word_idx == IPV4_W_DST_LO)) begin
            dst_lo_ok <= (Rx_Data[15:0] == My_IP[15:0]);
         end
         if (state == ST_CHECK) begin
            Err_Dst <= dst_err;
         end
      end
   end
`else
   logic unused_my_ip;

   assign unused_my_ip = ^My_IP;
   assign dst_err      = 1'b0;
   assign Err_Dst      = 1'b0;
`endif

   ipv4_csum_fold u_fold (
      .clock    (Clock),
      .reset    (Reset),
      .fold1_en (state == ST_FOLD1),
      .fold2_en (state == ST_FOLD2),
      .acc      (acc),
      .sum16    (sum16)
   );

endmodule
